// File: rtl/nv_nvdla_hls_shrsu_arb.sv
// Two-requester round-robin arbiter feeding one shared signed shift-right/round/saturate
// datapath, with a registered output stage and per-requester clip event counters.
module nv_nvdla_hls_shrsu_arb #(
   parameter int IN_WIDTH    = 49,
   parameter int OUT_WIDTH   = 32,
   parameter int SHIFT_WIDTH = 6,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                          nvdla_core_clk,
   input  logic                          nvdla_core_rstn,
   input  logic                          req0_pvld,
   output logic                          req0_prdy,
   input  logic signed [IN_WIDTH-1:0]    req0_data,
   input  logic        [SHIFT_WIDTH-1:0] req0_shift,
   input  logic                          req1_pvld,
   output logic                          req1_prdy,
   input  logic signed [IN_WIDTH-1:0]    req1_data,
   input  logic        [SHIFT_WIDTH-1:0] req1_shift,
   output logic                          out_pvld,
   input  logic                          out_prdy,
   output logic signed [OUT_WIDTH-1:0]   out_data,
   output logic                          out_src,
   output logic                          out_clip,
   input  logic                          clip_cnt_clr,
   output logic        [CNT_WIDTH-1:0]   clip_cnt0,
   output logic        [CNT_WIDTH-1:0]   clip_cnt1
);

   localparam logic [SHIFT_WIDTH-1:0] SH_ONE  = 1;
   localparam logic [IN_WIDTH-1:0]    D_ONE   = 1;
   localparam logic [CNT_WIDTH-1:0]   CNT_ONE = 1;

   // Arithmetic shift right with round-half-away-from-zero; one extra bit keeps the
   // rounding increment from wrapping.
   function automatic logic signed [IN_WIDTH:0] round_shift(
      input logic signed [IN_WIDTH-1:0]    d,
      input logic        [SHIFT_WIDTH-1:0] sh
   );
      logic signed [IN_WIDTH:0] ext;
      logic        [IN_WIDTH-1:0] mask;
      logic guide, sticky, inc;
      ext    = {d[IN_WIDTH-1], d};
      guide  = 1'b0;
      sticky = 1'b0;
      mask   = '0;
      if (int'(sh) >= IN_WIDTH) return '0;
      if (sh != '0) begin
         guide  = d[sh - SH_ONE];
         mask   = (D_ONE << (sh - SH_ONE)) - D_ONE;
         sticky = |(d & mask);
      end
      inc = guide & (~d[IN_WIDTH-1] | sticky);
      return (ext >>> sh) + $signed({{IN_WIDTH{1'b0}}, inc});
   endfunction

   // Returns {clip, value}; clip only when the value actually left the output range.
   function automatic logic [OUT_WIDTH:0] saturate(input logic signed [IN_WIDTH:0] v);
      logic [IN_WIDTH-OUT_WIDTH+1:0] hi;
      hi = v[IN_WIDTH:OUT_WIDTH-1];
      if ((&hi) || (~|hi)) return {1'b0, v[OUT_WIDTH-1:0]};
      else if (v[IN_WIDTH]) return {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
      else                  return {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
   endfunction

   logic                          last_gnt;
   logic                          load_en;
   logic                          gnt0, gnt1, accept;
   logic signed [IN_WIDTH-1:0]    op_data_p0;
   logic        [SHIFT_WIDTH-1:0] op_shift_p0;
   logic        [OUT_WIDTH:0]     sat_p0;
   logic                          vld_p1;
   logic signed [OUT_WIDTH-1:0]   data_p1;
   logic                          src_p1, clip_p1;
   logic        [CNT_WIDTH-1:0]   cnt0, cnt1;

   // Stage p0: arbitration and shared datapath on the granted operand
   assign load_en = ~vld_p1 | out_prdy;
   assign gnt0    = nvdla_core_rstn & load_en & req0_pvld & (~req1_pvld |  last_gnt);
   assign gnt1    = nvdla_core_rstn & load_en & req1_pvld & (~req0_pvld | ~last_gnt);
   assign accept  = gnt0 | gnt1;

   assign req0_prdy   = gnt0;
   assign req1_prdy   = gnt1;
   assign op_data_p0  = gnt1 ? req1_data  : req0_data;
   assign op_shift_p0 = gnt1 ? req1_shift : req0_shift;
   assign sat_p0      = saturate(round_shift(op_data_p0, op_shift_p0));

   // Stage p1: output register and arbitration pointer
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         vld_p1   <= 1'b0;
         data_p1  <= '0;
         src_p1   <= 1'b0;
         clip_p1  <= 1'b0;
         last_gnt <= 1'b1;
      end else if (accept) begin
         vld_p1   <= 1'b1;
         data_p1  <= sat_p0[OUT_WIDTH-1:0];
         src_p1   <= gnt1;
         clip_p1  <= sat_p0[OUT_WIDTH];
         last_gnt <= gnt1;
      end else if (out_prdy) begin
         vld_p1   <= 1'b0;
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else if (clip_cnt_clr) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (gnt0 && sat_p0[OUT_WIDTH] && !(&cnt0)) cnt0 <= cnt0 + CNT_ONE;
         if (gnt1 && sat_p0[OUT_WIDTH] && !(&cnt1)) cnt1 <= cnt1 + CNT_ONE;
      end
   end

   assign out_pvld  = vld_p1;
   assign out_data  = data_p1;
   assign out_src   = src_p1;
   assign out_clip  = clip_p1;
   assign clip_cnt0 = cnt0;
   assign clip_cnt1 = cnt1;

endmodule
